// File: rtl/bus_matrix_pkg.sv
// Shared sizing helpers for bus matrix buffering blocks.
// Used to size counters and pointers and to validate parameters at elaboration.
package bus_matrix_pkg;

  localparam int BM_MIN_DEPTH = 2;

  // Width needed to hold an occupancy of 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic bit params_ok(input int depth, input int afull_level);
    return (depth >= BM_MIN_DEPTH) && (afull_level >= 1) && (afull_level <= depth);
  endfunction

endpackage

// File: rtl/bus_matrix_elastic_buffer.sv
// Fully registered circular-buffer elastic stage for valid/ready channels.
// All outputs derive from flops only; depth need not be a power of two.
module bus_matrix_elastic_buffer
  import bus_matrix_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 2,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush_i,
  input  logic [WIDTH-1:0]                data_i,
  input  logic                            valid_i,
  output logic                            ready_o,
  output logic [WIDTH-1:0]                data_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [$clog2(DEPTH+1)-1:0]      level_o,
  output logic                            almost_full_o
);

  localparam int CW = count_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  if (!params_ok(DEPTH, AFULL_LEVEL)) begin : g_param_err
    $error("bus_matrix_elastic_buffer: DEPTH must be >= 2 and AFULL_LEVEL within 1..DEPTH");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             afull_q, afull_d;
  logic             push, pop;

  // Wrap by explicit compare so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign push = valid_i & ready_q;
  assign pop  = valid_q & ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push) - CW'(pop);
    end
    ready_d = (count_d < CW'(DEPTH));
    valid_d = (count_d != '0);
    afull_d = (count_d >= CW'(AFULL_LEVEL));
  end

  // Storage is deliberately left out of reset; only control state clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      if (push && !flush_i) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      afull_q  <= afull_d;
    end
  end

  assign ready_o       = ready_q;
  assign valid_o       = valid_q;
  assign data_o        = valid_q ? mem_q[rd_ptr_q] : '0;
  assign level_o       = count_q;
  assign almost_full_o = afull_q;

endmodule

// File: tb/tb_bus_matrix_elastic_buffer.sv
// Randomized and directed bench for bus_matrix_elastic_buffer (DEPTH=3)
// against a queue-based reference model.
module tb_bus_matrix_elastic_buffer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 3;
  localparam int AFULL = 2;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush_i;
  logic [WIDTH-1:0] data_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             ready_i;
  logic [LW-1:0]    level_o;
  logic             almost_full_o;

  int n_checks = 0;
  int n_err    = 0;
  logic [WIDTH-1:0] model_q [$];

  bus_matrix_elastic_buffer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .level_o(level_o), .almost_full_o(almost_full_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string phase);
    int sz;
    sz = model_q.size();
    check_eq({phase, ".ready"}, 32'(ready_o), 32'(sz < DEPTH));
    check_eq({phase, ".valid"}, 32'(valid_o), 32'(sz != 0));
    check_eq({phase, ".data"},  32'(data_o),  (sz != 0) ? 32'(model_q[0]) : 32'd0);
    check_eq({phase, ".level"}, 32'(level_o), 32'(sz));
    check_eq({phase, ".afull"}, 32'(almost_full_o), 32'(sz >= AFULL));
  endtask

  // Check current outputs, apply one cycle of inputs, advance the model.
  task automatic step(input string phase, input logic v, input logic [WIDTH-1:0] d,
                      input logic r, input logic f, output logic accepted);
    logic exp_ready, exp_valid;
    check_outputs(phase);
    valid_i = v; data_i = d; ready_i = r; flush_i = f;
    exp_ready = (model_q.size() < DEPTH);
    exp_valid = (model_q.size() != 0);
    accepted  = v && exp_ready && !f;
    @(posedge clk);
    if (f) model_q.delete();
    else begin
      if (exp_valid && r) void'(model_q.pop_front());
      if (v && exp_ready) model_q.push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    logic acc;
    int   pushes;

    // Reset held with valid_i high: nothing may be captured.
    rst_n = 1'b0; flush_i = 1'b0; valid_i = 1'b1; data_i = 16'h0055; ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_outputs("reset");
    end
    rst_n = 1'b1;
    #1 check_outputs("release");
    valid_i = 1'b0;
    @(negedge clk);

    // Streaming with downstream always ready.
    for (int i = 1; i <= 16; i++) step("stream", 1'b1, WIDTH'(i), 1'b1, 1'b0, acc);
    for (int i = 0; i < 3; i++) step("drain", 1'b0, '0, 1'b1, 1'b0, acc);

    // Fill and stall, then release.
    step("fill", 1'b1, 16'h000A, 1'b0, 1'b0, acc);
    step("fill", 1'b1, 16'h000B, 1'b0, 1'b0, acc);
    step("fill", 1'b1, 16'h000C, 1'b0, 1'b0, acc);
    step("full", 1'b1, 16'h00DD, 1'b0, 1'b0, acc);
    for (int i = 0; i < 4; i++) step("unstall", 1'b0, '0, 1'b1, 1'b0, acc);

    // Ten pushes across pointer wrap with random backpressure.
    pushes = 0;
    for (int i = 0; i < 200 && pushes < 10; i++) begin
      step("wrap", 1'b1, WIDTH'(16'h0100 + pushes), 1'($urandom_range(0, 1)), 1'b0, acc);
      if (acc) pushes++;
    end
    check_eq("wrap.pushes", 32'(pushes), 32'd10);
    for (int i = 0; i < 4; i++) step("wrap_drain", 1'b0, '0, 1'b1, 1'b0, acc);

    // Flush colliding with push and pop at level 2.
    step("pre_flush", 1'b1, 16'h0E01, 1'b0, 1'b0, acc);
    step("pre_flush", 1'b1, 16'h0E02, 1'b0, 1'b0, acc);
    step("flush", 1'b1, 16'h0E03, 1'b1, 1'b1, acc);
    for (int i = 0; i < 3; i++) step("post_flush", 1'b0, '0, 1'b1, 1'b0, acc);

    // Asynchronous reset mid-burst.
    step("pre_rst", 1'b1, 16'h0F01, 1'b0, 1'b0, acc);
    step("pre_rst", 1'b1, 16'h0F02, 1'b0, 1'b0, acc);
    check_eq("pre_rst.level", 32'(level_o), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_rst.valid", 32'(valid_o), 32'd0);
    check_eq("async_rst.ready", 32'(ready_o), 32'd1);
    check_eq("async_rst.level", 32'(level_o), 32'd0);
    model_q.delete();
    valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b1, 16'h0F77, 1'b0, 1'b0, acc);
    step("post_rst", 1'b0, '0, 1'b1, 1'b0, acc);
    step("post_rst", 1'b0, '0, 1'b1, 1'b0, acc);

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 1)), WIDTH'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0), acc);
    check_outputs("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_matrix_elastic_buffer.md
# bus_matrix_elastic_buffer

Parametrised, fully registered elastic buffer for valid/ready channels inside the bus matrix. It replaces single-entry forward/backward slices where a path needs both timing isolation and more than one cycle of slack. Examples are the long request paths between master ports and the arbitration stage, and response return paths. `ready_o`, `valid_o` and `data_o` have no combinational path from `valid_i`, `data_i` or `ready_i`. The buffer sustains one transfer per cycle at any depth of 2 or more.

## Interface
- `WIDTH`, 32: payload width in bits; must be 1 or more.
- `DEPTH`, 2: number of entries; must be 2 or more, and need not be a power of two.
- `AFULL_LEVEL`, `DEPTH-1`: occupancy at which `almost_full_o` asserts; range 1..`DEPTH`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `flush_i`  in  1  synchronous discard of all stored entries.
- `data_i`  in  `WIDTH`  upstream payload.
- `valid_i`  in  1  upstream valid.
- `ready_o`  out  1  upstream ready; registered.
- `data_o`  out  `WIDTH`  downstream payload.
- `valid_o`  out  1  downstream valid; registered.
- `ready_i`  in  1  downstream ready.
- `level_o`  out  `$clog2(DEPTH+1)`  current occupancy.
- `almost_full_o`  out  1  asserted when `level_o` ≥ `AFULL_LEVEL`; registered.

## Operation
- Storage is a circular array of `DEPTH` entries with a write pointer, a read pointer and an occupancy counter `count`.
- Pointers wrap from `DEPTH-1` to 0 by explicit compare, not by modulo-2^n.
- push = `valid_i & ready_o`. On a push, `data_i` is written at the write pointer and the write pointer advances.
- pop = `valid_o & ready_i`. On a pop, the read pointer advances.
- Next count = count + push − pop.
  - Push and pop in the same cycle leave count unchanged.
  - Both pointers still advance.
- `ready_o` is 1 when `count < DEPTH`.
  - It must be produced from registered state only: either a dedicated flop or a compare of the count register.
  - It must never depend on `ready_i` in the same cycle.
- `valid_o` is 1 when `count != 0`.
- `data_o` is the entry at the read pointer when `valid_o` is 1, and `'0` otherwise.
- Full (`count == DEPTH`):
  - `ready_o` is 0, so `valid_i` is ignored.
  - A pop in this cycle makes `ready_o` 1 in the next cycle. There is no same-cycle pass-through.
- Empty (`count == 0`): `valid_o` is 0 and `ready_i` is ignored.
- Flush:
  - `flush_i` = 1 takes priority over push and pop in the same cycle.
  - Pointers and count go to 0, so the next cycle shows `valid_o` = 0 and `ready_o` = 1.
  - The payload presented in the flush cycle is dropped even if `valid_i` and `ready_o` were both 1.
  - Upstream owns that loss.
- Payload order is strictly FIFO. There is no bypass path, so the minimum latency is 1 cycle.
- Storage flops are not reset. Reset clears only pointers, count and the registered flags.

## Timing
- Reset values, applied asynchronously on `rst_n` low:
  - `ready_o` = 1
  - `valid_o` = 0
  - `data_o` = 0
  - `level_o` = 0
  - `almost_full_o` = 0
- Reset asserted mid-operation discards all entries immediately, with no drain.
- Latency: a payload accepted at edge N appears on `valid_o`/`data_o` after edge N, i.e. in cycle N+1, when the buffer was empty. Otherwise it appears after all older entries have popped.
- Throughput: 1 transfer per cycle sustained while `valid_i` and `ready_i` are held at 1. Occupancy settles at 1.
- Backpressure: after `ready_i` drops, upstream can push at most `DEPTH − count` more entries before `ready_o` falls. `ready_o` falls in the cycle after the last accepted push.
- `level_o` and `almost_full_o` update on the same edge as count.
- Holding `valid_i` = 1 with stable `data_i` while `ready_o` = 0 is the upstream's obligation. The buffer does not check it.

## Structure
- `bus_matrix_pkg` holds the shared constant and parameter-check helpers:
  - a function returning the count width for a given depth;
  - a function returning the pointer width, `$clog2(DEPTH)` with a minimum of 1.
- An elaboration-time check rejects `DEPTH` < 2 and `AFULL_LEVEL` outside 1..`DEPTH`.
- No sub-module: storage array, pointers and count sit in one always_ff block with the registered flags.
- `bus_matrix_elastic_buffer` with `DEPTH`=2 is the drop-in successor wherever both forward and backward registering were enabled on a single-entry slice.

## Test plan
- Reset then idle: `rst_n` low for 3 cycles with `valid_i`=1 → `ready_o`=1, `valid_o`=0, `level_o`=0, `data_o`=0 throughout; nothing is stored after release until the first edge with `rst_n` high.
- Streaming, `DEPTH`=2: push 0x1, 0x2, …, 0x10 on consecutive cycles with `ready_i`=1 → outputs appear one cycle later in order, with no bubble and `level_o` constant at 1.
- Fill and stall, `DEPTH`=3: `ready_i`=0, push 0xA, 0xB, 0xC → `ready_o` goes 0 after the third push, `level_o`=3, `almost_full_o`=1 from `level_o`=2; then `ready_i`=1 → 0xA, 0xB, 0xC emerge on consecutive cycles and `ready_o` returns to 1 one cycle after the first pop.
- Pointer wrap at a non-power-of-two depth, `DEPTH`=3: 10 pushes interleaved with a random `ready_i` pattern → order is preserved across wrap and `level_o` never exceeds 3.
- Flush collision: with `level_o`=2, assert `flush_i` with `valid_i`=1 and `ready_i`=1 → next cycle `valid_o`=0 and `level_o`=0; neither the in-flight payload nor the stored payloads ever appear.
- Asynchronous reset mid-burst: drop `rst_n` between edges while `level_o`=2 → `valid_o`=0 and `ready_o`=1 immediately, without waiting for an edge; the first push after release emerges with the correct data.
